// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM states, forwarding selects,
// and the register-match helper that keeps x0 out of every hazard/forward decision.
package hazard_ctrl_pkg;

  typedef enum logic [0:0] {
    ST_RUN      = 1'b0,
    ST_MEM_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_ME  = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  function automatic logic reg_match(input logic [4:0] dst, input logic [4:0] src,
                                     input logic we);
    return we && (dst == src) && (dst != 5'd0);
  endfunction

endpackage

// File: rtl/hazard_fwd_sel.sv
// Forwarding select for one EX source operand; ME result wins over WB, ME loads are not
// forwardable because their data is not ready until WB.
module hazard_fwd_sel
  import hazard_ctrl_pkg::*;
(
  input  logic [4:0] src_addr,
  input  logic [4:0] me_rd_addr,
  input  logic       me_write_reg_enable,
  input  logic       me_load,
  input  logic [4:0] wb_rd_addr,
  input  logic       wb_write_reg_enable,
  output logic [1:0] sel
);

  always_comb begin
    sel = FWD_REG;
    if (reg_match(me_rd_addr, src_addr, me_write_reg_enable) && !me_load)
      sel = FWD_ME;
    else if (reg_match(wb_rd_addr, src_addr, wb_write_reg_enable))
      sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward sequencer for the 5-stage pipe. Optional operand forwarding is enabled
// with `define HAZARD_FWD_EN (hazards reduce to load-use only); default build stalls on any RAW.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_write_reg_enable,
  input  logic [2:0]       ex_read_ram_flag,
  input  logic [4:0]       me_rd_addr,
  input  logic             me_write_reg_enable,
  input  logic [2:0]       me_read_ram_flag,
  input  logic [1:0]       me_write_ram_flag,
  input  logic             me_branch_enable,
  input  logic [4:0]       wb_rd_addr,
  input  logic             wb_write_reg_enable,
  input  logic             dmem_ready,
  output logic             pc_stall,
  output logic             if_id_stall,
  output logic             id_ex_stall,
  output logic             ex_me_stall,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_me_flush,
  output logic             me_wb_flush,
  output logic [1:0]       fwd_rs1_sel,
  output logic [1:0]       fwd_rs2_sel,
  output logic             mem_fault,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int TW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);

  state_t        state;
  logic [TW-1:0] wait_cnt;
  logic          me_access;
  logic          mem_wait;
  logic          branch_go;
  logic          data_hazard;

  assign me_access = (me_read_ram_flag != 3'd0) || (me_write_ram_flag != 2'd0);
  // A faulted access keeps the pipe frozen until reset, even if the RAM answers late.
  assign mem_wait  = mem_fault ||
                     ((me_access || (state == ST_MEM_WAIT)) && !dmem_ready);
  assign branch_go = me_branch_enable && !mem_wait;

`ifdef HAZARD_FWD_EN
  logic [4:0] ex_rs1_addr;
  logic [4:0] ex_rs2_addr;
  logic [1:0] sel_rs1;
  logic [1:0] sel_rs2;

  // Only a load in EX cannot be forwarded in time; everything else goes through the muxes.
  assign data_hazard = (ex_read_ram_flag != 3'd0) &&
                       (reg_match(ex_rd_addr, id_rs1_addr, ex_write_reg_enable) ||
                        reg_match(ex_rd_addr, id_rs2_addr, ex_write_reg_enable));

  // Shadow of the id_ex source fields so the selects describe the instruction now in EX.
  always_ff @(posedge clk) begin
    if (rst || id_ex_flush) begin
      ex_rs1_addr <= 5'd0;
      ex_rs2_addr <= 5'd0;
    end else if (!id_ex_stall) begin
      ex_rs1_addr <= id_rs1_addr;
      ex_rs2_addr <= id_rs2_addr;
    end
  end

  hazard_fwd_sel u_fwd_rs1 (
    .src_addr            (ex_rs1_addr),
    .me_rd_addr          (me_rd_addr),
    .me_write_reg_enable (me_write_reg_enable),
    .me_load             (me_read_ram_flag != 3'd0),
    .wb_rd_addr          (wb_rd_addr),
    .wb_write_reg_enable (wb_write_reg_enable),
    .sel                 (sel_rs1)
  );

  hazard_fwd_sel u_fwd_rs2 (
    .src_addr            (ex_rs2_addr),
    .me_rd_addr          (me_rd_addr),
    .me_write_reg_enable (me_write_reg_enable),
    .me_load             (me_read_ram_flag != 3'd0),
    .wb_rd_addr          (wb_rd_addr),
    .wb_write_reg_enable (wb_write_reg_enable),
    .sel                 (sel_rs2)
  );

  assign fwd_rs1_sel = rst ? FWD_REG : sel_rs1;
  assign fwd_rs2_sel = rst ? FWD_REG : sel_rs2;
`else
  logic unused_ok;

  // The register file writes before it reads, so a WB producer never needs a stall.
  assign data_hazard = reg_match(ex_rd_addr, id_rs1_addr, ex_write_reg_enable) ||
                       reg_match(ex_rd_addr, id_rs2_addr, ex_write_reg_enable) ||
                       reg_match(me_rd_addr, id_rs1_addr, me_write_reg_enable) ||
                       reg_match(me_rd_addr, id_rs2_addr, me_write_reg_enable);

  assign unused_ok   = ^{ex_read_ram_flag, wb_rd_addr, wb_write_reg_enable};
  assign fwd_rs1_sel = FWD_REG;
  assign fwd_rs2_sel = FWD_REG;
`endif

  always_comb begin
    pc_stall    = 1'b0;
    if_id_stall = 1'b0;
    id_ex_stall = 1'b0;
    ex_me_stall = 1'b0;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    me_wb_flush = 1'b0;
    if (rst) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_me_flush = 1'b1;
      me_wb_flush = 1'b1;
    end else if (branch_go) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_me_flush = 1'b1;
    end else if (mem_wait) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_stall = 1'b1;
      ex_me_stall = 1'b1;
      me_wb_flush = 1'b1;
    end else if (data_hazard) begin
      pc_stall    = 1'b1;
      if_id_stall = 1'b1;
      id_ex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_RUN;
      wait_cnt  <= '0;
      mem_fault <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (pc_stall && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
      case (state)
        ST_RUN: begin
          if (me_access && !dmem_ready) begin
            state    <= ST_MEM_WAIT;
            wait_cnt <= '0;
          end
        end
        ST_MEM_WAIT: begin
          if (!mem_fault) begin
            if (dmem_ready) begin
              state    <= ST_RUN;
              wait_cnt <= '0;
            end else if (wait_cnt == TW'(MEM_TIMEOUT - 1)) begin
              mem_fault <= 1'b1;
            end else begin
              wait_cnt <= wait_cnt + 1'b1;
            end
          end
        end
        default: begin
          state    <= ST_RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl (MEM_TIMEOUT=4, CNT_W=4 so timeout and
// counter saturation are reachable quickly); covers both HAZARD_FWD_EN builds.
module tb_hazard_ctrl;

  localparam logic [7:0] C_NONE = 8'b0000_0000;
  localparam logic [7:0] C_RST  = 8'b0000_1111;
  localparam logic [7:0] C_HAZ  = 8'b1100_0100;
  localparam logic [7:0] C_BR   = 8'b0000_1110;
  localparam logic [7:0] C_MW   = 8'b1111_0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr, me_rd_addr, wb_rd_addr;
  logic       ex_write_reg_enable, me_write_reg_enable, wb_write_reg_enable;
  logic [2:0] ex_read_ram_flag, me_read_ram_flag;
  logic [1:0] me_write_ram_flag;
  logic       me_branch_enable, dmem_ready;
  logic       pc_stall, if_id_stall, id_ex_stall, ex_me_stall;
  logic       if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush;
  logic [1:0] fwd_rs1_sel, fwd_rs2_sel;
  logic       mem_fault;
  logic [3:0] stall_cnt;

  typedef struct {
    string      tag;
    logic [7:0] ctrl;
    logic [1:0] f1;
    logic [1:0] f2;
    logic       fault;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   exp_cnt = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .ex_rd_addr(ex_rd_addr), .ex_write_reg_enable(ex_write_reg_enable),
    .ex_read_ram_flag(ex_read_ram_flag),
    .me_rd_addr(me_rd_addr), .me_write_reg_enable(me_write_reg_enable),
    .me_read_ram_flag(me_read_ram_flag), .me_write_ram_flag(me_write_ram_flag),
    .me_branch_enable(me_branch_enable),
    .wb_rd_addr(wb_rd_addr), .wb_write_reg_enable(wb_write_reg_enable),
    .dmem_ready(dmem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_me_stall(ex_me_stall),
    .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush),
    .me_wb_flush(me_wb_flush),
    .fwd_rs1_sel(fwd_rs1_sel), .fwd_rs2_sel(fwd_rs2_sel),
    .mem_fault(mem_fault), .stall_cnt(stall_cnt)
  );

  task automatic clr();
    id_rs1_addr = 5'd0; id_rs2_addr = 5'd0;
    ex_rd_addr = 5'd0; ex_write_reg_enable = 1'b0; ex_read_ram_flag = 3'd0;
    me_rd_addr = 5'd0; me_write_reg_enable = 1'b0; me_read_ram_flag = 3'd0;
    me_write_ram_flag = 2'd0; me_branch_enable = 1'b0;
    wb_rd_addr = 5'd0; wb_write_reg_enable = 1'b0;
    dmem_ready = 1'b1;
  endtask

  // Inputs are already driven (at a negedge); push the expectation, check the combinational
  // controls mid-cycle, then pop after the edge and check the registered outputs.
  task automatic step(input string tag, input logic [7:0] ctrl, input logic [1:0] f1,
                      input logic [1:0] f2, input logic fault);
    exp_t e;
    logic [7:0] obs;
    e.tag = tag; e.ctrl = ctrl; e.f1 = f1; e.f2 = f2; e.fault = fault;
    sbq.push_back(e);
    #1;
    e = sbq[0];
    obs = {pc_stall, if_id_stall, id_ex_stall, ex_me_stall,
           if_id_flush, id_ex_flush, ex_me_flush, me_wb_flush};
    checks++;
    assert (obs === e.ctrl) begin passes++; end
    else $error("FAIL %s ctrl observed=%b expected=%b", e.tag, obs, e.ctrl);
    checks++;
    assert ({fwd_rs1_sel, fwd_rs2_sel} === {e.f1, e.f2}) begin passes++; end
    else $error("FAIL %s fwd observed=%b/%b expected=%b/%b", e.tag,
                fwd_rs1_sel, fwd_rs2_sel, e.f1, e.f2);
    @(posedge clk);
    #1;
    e = sbq.pop_front();
    if (rst) exp_cnt = 0;
    else if (e.ctrl[7] && exp_cnt < 15) exp_cnt++;
    checks++;
    assert ({mem_fault, stall_cnt} === {e.fault, 4'(exp_cnt)}) begin passes++; end
    else $error("FAIL %s regs observed fault=%b cnt=%0d expected fault=%b cnt=%0d",
                e.tag, mem_fault, stall_cnt, e.fault, exp_cnt);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    clr();
    @(negedge clk);
    step("reset", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;

`ifdef HAZARD_FWD_EN
    clr(); ex_rd_addr = 5'd5; ex_write_reg_enable = 1'b1; ex_read_ram_flag = 3'd1;
    id_rs1_addr = 5'd5;
    step("lu_stall", C_HAZ, 2'b00, 2'b00, 1'b0);
    clr(); me_rd_addr = 5'd5; me_write_reg_enable = 1'b1; me_read_ram_flag = 3'd1;
    id_rs1_addr = 5'd5;
    step("lu_release", C_NONE, 2'b00, 2'b00, 1'b0);
    clr(); wb_rd_addr = 5'd5; wb_write_reg_enable = 1'b1;
    step("lu_fwd_wb", C_NONE, 2'b10, 2'b00, 1'b0);
    clr(); id_rs1_addr = 5'd7; id_rs2_addr = 5'd7;
    step("x7_issue", C_NONE, 2'b00, 2'b00, 1'b0);
    clr(); me_rd_addr = 5'd7; me_write_reg_enable = 1'b1;
    wb_rd_addr = 5'd7; wb_write_reg_enable = 1'b1;
    step("fwd_me_prio", C_NONE, 2'b01, 2'b01, 1'b0);
    clr(); me_rd_addr = 5'd0; me_write_reg_enable = 1'b1;
    wb_rd_addr = 5'd0; wb_write_reg_enable = 1'b1;
    step("fwd_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    clr(); id_rs2_addr = 5'd3;
    step("x3_issue", C_NONE, 2'b00, 2'b00, 1'b0);
    clr(); me_rd_addr = 5'd3; me_write_reg_enable = 1'b1; me_read_ram_flag = 3'd2;
    wb_rd_addr = 5'd3; wb_write_reg_enable = 1'b1;
    step("fwd_me_load_skip", C_NONE, 2'b00, 2'b10, 1'b0);
    clr(); ex_rd_addr = 5'd5; ex_write_reg_enable = 1'b1; id_rs1_addr = 5'd5;
    step("alu_no_stall", C_NONE, 2'b00, 2'b00, 1'b0);
`else
    clr(); ex_rd_addr = 5'd5; ex_write_reg_enable = 1'b1; id_rs1_addr = 5'd5;
    step("raw_ex", C_HAZ, 2'b00, 2'b00, 1'b0);
    clr(); me_rd_addr = 5'd5; me_write_reg_enable = 1'b1; id_rs1_addr = 5'd5;
    step("raw_me", C_HAZ, 2'b00, 2'b00, 1'b0);
    clr(); wb_rd_addr = 5'd5; wb_write_reg_enable = 1'b1; id_rs1_addr = 5'd5;
    step("raw_wb_free", C_NONE, 2'b00, 2'b00, 1'b0);
    clr(); ex_write_reg_enable = 1'b1; me_write_reg_enable = 1'b1;
    step("raw_x0", C_NONE, 2'b00, 2'b00, 1'b0);
    clr(); me_rd_addr = 5'd9; me_write_reg_enable = 1'b1; id_rs2_addr = 5'd9;
    step("raw_rs2_me", C_HAZ, 2'b00, 2'b00, 1'b0);
    clr(); ex_rd_addr = 5'd4; ex_write_reg_enable = 1'b1;
    id_rs1_addr = 5'd5; id_rs2_addr = 5'd6;
    step("no_match", C_NONE, 2'b00, 2'b00, 1'b0);
`endif

    // Branch in ME beats a pending load-use hazard.
    clr(); ex_rd_addr = 5'd5; ex_write_reg_enable = 1'b1; ex_read_ram_flag = 3'd1;
    id_rs1_addr = 5'd5; me_branch_enable = 1'b1;
    step("branch_wins", C_BR, 2'b00, 2'b00, 1'b0);

    // Load stalled three cycles; the branch it carries is taken only once data arrives.
    clr(); me_read_ram_flag = 3'd1; me_branch_enable = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("mem_freeze", C_MW, 2'b00, 2'b00, 1'b0);
    dmem_ready = 1'b1;
    step("mem_release_br", C_BR, 2'b00, 2'b00, 1'b0);
    clr(); dmem_ready = 1'b0;
    step("back_in_run", C_NONE, 2'b00, 2'b00, 1'b0);

    clr(); ex_rd_addr = 5'd5; ex_write_reg_enable = 1'b1; ex_read_ram_flag = 3'd1;
    id_rs1_addr = 5'd5;
    for (int i = 0; i < 16; i++) step("cnt_sat", C_HAZ, 2'b00, 2'b00, 1'b0);
    checks++;
    assert (stall_cnt === 4'hF) begin passes++; end
    else $error("FAIL cnt_sat_final observed=%0d expected=15", stall_cnt);

    // Timeout: fault appears after four MEM_WAIT cycles and sticks until reset.
    rst = 1'b1; clr();
    step("reset2", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    clr(); me_write_ram_flag = 2'd1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) step("tmo_wait", C_MW, 2'b00, 2'b00, 1'b0);
    step("tmo_fault", C_MW, 2'b00, 2'b00, 1'b1);
    step("tmo_hold", C_MW, 2'b00, 2'b00, 1'b1);
    dmem_ready = 1'b1;
    step("tmo_sticky", C_MW, 2'b00, 2'b00, 1'b1);
    dmem_ready = 1'b0; rst = 1'b1;
    step("rst_mid_wait", C_RST, 2'b00, 2'b00, 1'b0);
    rst = 1'b0;
    clr(); dmem_ready = 1'b0;
    step("post_rst_run", C_NONE, 2'b00, 2'b00, 1'b0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
